// File: rtl/exec_pkg.sv
// Shared encodings for the handshaked execute unit: opcodes, funct3 codes,
// memory access widths and FSM states.
package exec_pkg;

  localparam int unsigned OP_W = 7;
  localparam int unsigned F3_W = 3;
  localparam int unsigned ACC_W = 2;

  localparam logic [OP_W-1:0] OP_LUI     = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC   = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL     = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR    = 7'b1100111;
  localparam logic [OP_W-1:0] OP_BRANCH  = 7'b1100011;
  localparam logic [OP_W-1:0] OP_LOAD    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_IMM     = 7'b0010011;
  localparam logic [OP_W-1:0] OP_INTEGER = 7'b0110011;

  localparam logic [OP_W-1:0] F7_MULDIV = 7'b0000001;

  localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
  localparam logic [F3_W-1:0] F3_SR   = 3'b101;
  localparam logic [F3_W-1:0] F3_OR   = 3'b110;
  localparam logic [F3_W-1:0] F3_AND  = 3'b111;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  localparam logic [ACC_W-1:0] MEM_ACC_8  = 2'b00;
  localparam logic [ACC_W-1:0] MEM_ACC_16 = 2'b01;
  localparam logic [ACC_W-1:0] MEM_ACC_32 = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_DONE,
    ST_MUL
  } state_e;

  // True when an access of this width at this address cannot be issued.
  function automatic logic acc_fault(input logic [ACC_W-1:0] width,
                                     input logic [1:0]       addr_lo,
                                     input logic             word_ok);
    case (width)
      MEM_ACC_8:  acc_fault = 1'b0;
      MEM_ACC_16: acc_fault = addr_lo[0];
      MEM_ACC_32: acc_fault = !word_ok || (addr_lo != 2'b00);
      default:    acc_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational XLEN-wide integer ALU and branch comparator.
module exec_alu
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [F3_W-1:0] funct3_i,
  input  logic            alt_i,
  output logic [XLEN-1:0] result_c_o,
  output logic            taken_c_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           eq, lt, ltu;

  assign shamt = b_i[SHW-1:0];
  assign eq    = (a_i == rs2_i);
  assign lt    = ($signed(a_i) < $signed(rs2_i));
  assign ltu   = (a_i < rs2_i);

  always_comb begin
    result_c_o = '0;
    case (funct3_i)
      F3_ADD:  result_c_o = alt_i ? (a_i - b_i) : (a_i + b_i);
      F3_SLL:  result_c_o = a_i << shamt;
      F3_SLT:  result_c_o = XLEN'($signed(a_i) < $signed(b_i));
      F3_SLTU: result_c_o = XLEN'(a_i < b_i);
      F3_XOR:  result_c_o = a_i ^ b_i;
      F3_SR:   result_c_o = alt_i ? XLEN'($signed(a_i) >>> shamt) : (a_i >> shamt);
      F3_OR:   result_c_o = a_i | b_i;
      F3_AND:  result_c_o = a_i & b_i;
      default: result_c_o = '0;
    endcase
  end

  always_comb begin
    taken_c_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_c_o = eq;
      F3_BNE:  taken_c_o = !eq;
      F3_BLT:  taken_c_o = lt;
      F3_BGE:  taken_c_o = !lt;
      F3_BLTU: taken_c_o = ltu;
      F3_BGEU: taken_c_o = !ltu;
      default: taken_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Handshaked single-issue execute stage: ALU, branches/jumps, loads/stores.
// Define EXEC_UNIT_MUL_EN to add an iterative shift-add MUL.
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [F3_W-1:0]  funct3,
  input  logic [OP_W-1:0]  funct7,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  val_out,
  output logic [XLEN-1:0]  pc_out,
  output logic             redirect,
  output logic             trap,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_data_out,
  output logic [ACC_W-1:0] mem_acc_width,
  input  logic [XLEN-1:0]  mem_data_in,
  input  logic             mem_ready
);

  localparam bit WORD_OK = (XLEN > 16);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d, f7_q, f7_d;
  logic [F3_W-1:0]   f3_q, f3_d;
  logic [XLEN-1:0]   pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic              redirect_q, redirect_d, trap_q, trap_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0]   val_q, val_d, pc_out_q, pc_out_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [ACC_W-1:0]  mem_width_q, mem_width_d;

  logic [XLEN-1:0]   alu_res, addr_sum, pc_plus_imm, pc_plus_4, load_ext, alu_b;
  logic              taken, alu_alt, is_mul, is_reg;

`ifdef EXEC_UNIT_MUL_EN
  localparam int unsigned CNT_W = $clog2(XLEN);
  logic [XLEN-1:0]  mul_acc_q, mul_acc_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
`endif

  assign is_reg      = (op_q == OP_INTEGER);
  assign is_mul      = is_reg && (f7_q == F7_MULDIV) && (f3_q == F3_ADD);
  assign alu_b       = is_reg ? rs2_q : imm_q;
  // SUB only for register form; SRA/SRAI both take funct7[5]
  assign alu_alt     = f7_q[5] && (is_reg || (f3_q == F3_SR));
  assign addr_sum    = rs1_q + imm_q;
  assign pc_plus_imm = pc_q + imm_q;
  assign pc_plus_4   = pc_q + XLEN'(4);

  exec_alu #(.XLEN(XLEN)) u_alu (
    .a_i        (rs1_q),
    .b_i        (alu_b),
    .rs2_i      (rs2_q),
    .funct3_i   (f3_q),
    .alt_i      (alu_alt),
    .result_c_o (alu_res),
    .taken_c_o  (taken)
  );

  always_comb begin
    case (f3_q)
      F3_LB:   load_ext = XLEN'($signed(mem_data_in[7:0]));
      F3_LH:   load_ext = XLEN'($signed(mem_data_in[15:0]));
      F3_LBU:  load_ext = XLEN'(mem_data_in[7:0]);
      F3_LHU:  load_ext = XLEN'(mem_data_in[15:0]);
      default: load_ext = mem_data_in;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    f3_d        = f3_q;
    f7_d        = f7_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    val_d       = val_q;
    pc_out_d    = pc_out_q;
    redirect_d  = redirect_q;
    trap_d      = trap_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_width_d = mem_width_q;
`ifdef EXEC_UNIT_MUL_EN
    mul_acc_d   = mul_acc_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_cnt_d   = mul_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d       = op;
          f3_d       = funct3;
          f7_d       = funct7;
          pc_d       = pc_in;
          rs1_d      = rs1;
          rs2_d      = rs2;
          imm_d      = imm;
          in_ready_d = 1'b0;
          state_d    = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        case (op_q)
          OP_LUI:   val_d = imm_q;
          OP_AUIPC: val_d = pc_plus_imm;
          OP_JAL: begin
            val_d      = pc_plus_4;
            pc_out_d   = pc_plus_imm;
            redirect_d = 1'b1;
          end
          OP_JALR: begin
            val_d      = pc_plus_4;
            pc_out_d   = {addr_sum[XLEN-1:1], 1'b0};
            redirect_d = 1'b1;
          end
          OP_BRANCH: begin
            val_d      = '0;
            redirect_d = taken;
            pc_out_d   = taken ? pc_plus_imm : pc_out_q;
          end
          OP_IMM: val_d = alu_res;
          OP_INTEGER: begin
            if (is_mul) begin
`ifdef EXEC_UNIT_MUL_EN
              out_valid_d = 1'b0;
              state_d     = ST_MUL;
              mul_acc_d   = '0;
              mul_a_d     = rs1_q;
              mul_b_d     = rs2_q;
              mul_cnt_d   = '0;
`else
              trap_d = 1'b1;
`endif
            end else begin
              val_d = alu_res;
            end
          end
          OP_LOAD, OP_STORE: begin
            if (acc_fault(f3_q[1:0], addr_sum[1:0], WORD_OK)) begin
              trap_d = 1'b1;
            end else begin
              out_valid_d = 1'b0;
              state_d     = ST_MEM;
              mem_req_d   = 1'b1;
              mem_we_d    = (op_q == OP_STORE);
              mem_addr_d  = addr_sum;
              mem_wdata_d = rs2_q;
              mem_width_d = f3_q[1:0];
            end
          end
          default: trap_d = 1'b1;
        endcase
      end

      ST_MEM: begin
        if (mem_ready) begin
          val_d       = mem_we_q ? '0 : load_ext;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_width_d = MEM_ACC_8;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

`ifdef EXEC_UNIT_MUL_EN
      ST_MUL: begin
        mul_acc_d = mul_b_q[0] ? (mul_acc_q + mul_a_q) : mul_acc_q;
        mul_a_d   = mul_a_q << 1;
        mul_b_d   = mul_b_q >> 1;
        mul_cnt_d = mul_cnt_q + CNT_W'(1);
        if (mul_cnt_q == CNT_W'(XLEN - 1)) begin
          val_d       = mul_acc_d;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          val_d       = '0;
          pc_out_d    = RESET_PC;
          redirect_d  = 1'b0;
          trap_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      f3_q        <= '0;
      f7_q        <= '0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      val_q       <= '0;
      pc_out_q    <= RESET_PC;
      redirect_q  <= 1'b0;
      trap_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_width_q <= MEM_ACC_8;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      f3_q        <= f3_d;
      f7_q        <= f7_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      val_q       <= val_d;
      pc_out_q    <= pc_out_d;
      redirect_q  <= redirect_d;
      trap_q      <= trap_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_width_q <= mem_width_d;
    end
  end

`ifdef EXEC_UNIT_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_acc_q <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_cnt_q <= '0;
    end else begin
      mul_acc_q <= mul_acc_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end
`endif

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign val_out       = val_q;
  assign pc_out        = pc_out_q;
  assign redirect      = redirect_q;
  assign trap          = trap_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data_out  = mem_wdata_q;
  assign mem_acc_width = mem_width_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit (XLEN=32, RESET_PC=0x1000).
module tb_exec_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RPC  = 32'h0000_1000;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [6:0]  op, funct7;
  logic [2:0]  funct3;
  logic [31:0] pc_in, rs1, rs2, imm, val_out, pc_out;
  logic        redirect, trap, mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_data_out, mem_data_in;
  logic [1:0]  mem_acc_width;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  int r0;

  exec_unit #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct3(funct3), .funct7(funct7),
    .pc_in(pc_in), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .val_out(val_out), .pc_out(pc_out), .redirect(redirect), .trap(trap),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .mem_acc_width(mem_acc_width),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req === 1'b1) req_cycles <= req_cycles + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one instruction, returns at the falling edge after acceptance.
  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im);
    op = o; funct3 = f3; funct7 = f7; pc_in = pc; rs1 = a; rs2 = b; imm = im;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mem_ready = 1'b0; mem_data_in = '0;
    op = '0; funct3 = '0; funct7 = '0; pc_in = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pc_out", pc_out, RPC);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_val_out", val_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ADDI: exact two-cycle latency
    issue(7'b0010011, 3'b000, 7'd0, 32'h10, 32'd5, 32'd0, 32'hFFFF_FFF9);
    chk("addi_early_valid", 32'(out_valid), 32'd0);
    chk("addi_busy_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_val", val_out, 32'hFFFF_FFFE);
    chk("addi_redirect", 32'(redirect), 32'd0);
    chk("addi_trap", 32'(trap), 32'd0);
    release_out("addi");
    chk("addi_idle_pc", pc_out, RPC);
    chk("addi_idle_valid", 32'(out_valid), 32'd0);

    issue(7'b0110011, 3'b000, 7'b0100000, 32'h0, 32'd10, 32'd3, 32'd0);
    wait_out("sub");
    chk("sub_val", val_out, 32'd7);
    release_out("sub");

    issue(7'b0010011, 3'b101, 7'b0100000, 32'h0, 32'h8000_0000, 32'd0, 32'h0000_0404);
    wait_out("srai");
    chk("srai_val", val_out, 32'hF800_0000);
    release_out("srai");

    issue(7'b0110011, 3'b010, 7'd0, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    wait_out("slt");
    chk("slt_val", val_out, 32'd0);
    release_out("slt");

    issue(7'b0110011, 3'b011, 7'd0, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    wait_out("sltu");
    chk("sltu_val", val_out, 32'd1);
    release_out("sltu");

    issue(7'b0110111, 3'b000, 7'd0, 32'h0, 32'd0, 32'd0, 32'h1234_5000);
    wait_out("lui");
    chk("lui_val", val_out, 32'h1234_5000);
    release_out("lui");

    issue(7'b0010111, 3'b000, 7'd0, 32'h100, 32'd0, 32'd0, 32'h1000);
    wait_out("auipc");
    chk("auipc_val", val_out, 32'h1100);
    release_out("auipc");

    issue(7'b1101111, 3'b000, 7'd0, 32'h80, 32'd0, 32'd0, 32'h10);
    wait_out("jal");
    chk("jal_val", val_out, 32'h84);
    chk("jal_pc", pc_out, 32'h90);
    chk("jal_redirect", 32'(redirect), 32'd1);
    release_out("jal");

    // LB with mem_ready delayed three cycles
    r0 = req_cycles;
    issue(7'b0000011, 3'b000, 7'd0, 32'h0, 32'h100, 32'd0, 32'd3);
    @(negedge clk);
    chk("lb_req", 32'(mem_req), 32'd1);
    chk("lb_addr", mem_addr, 32'h103);
    chk("lb_width", 32'(mem_acc_width), 32'd0);
    chk("lb_we", 32'(mem_we), 32'd0);
    repeat (2) @(negedge clk);
    chk("lb_req_held", 32'(mem_req), 32'd1);
    chk("lb_addr_held", mem_addr, 32'h103);
    @(negedge clk);
    mem_ready = 1'b1; mem_data_in = 32'h80;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("lb_req_cycles", 32'(req_cycles - r0), 32'd4);
    chk("lb_req_drop", 32'(mem_req), 32'd0);
    chk("lb_valid", 32'(out_valid), 32'd1);
    chk("lb_val", val_out, 32'hFFFF_FF80);
    release_out("lb");

    mem_ready = 1'b1; mem_data_in = 32'h80;
    issue(7'b0000011, 3'b100, 7'd0, 32'h0, 32'h100, 32'd0, 32'd3);
    wait_out("lbu");
    chk("lbu_val", val_out, 32'h0000_0080);
    release_out("lbu");

    mem_data_in = 32'h0000_8001;
    issue(7'b0000011, 3'b001, 7'd0, 32'h0, 32'h100, 32'd0, 32'd6);
    wait_out("lh");
    chk("lh_val", val_out, 32'hFFFF_8001);
    release_out("lh");

    mem_ready = 1'b0;
    issue(7'b0100011, 3'b010, 7'd0, 32'h0, 32'h200, 32'hDEAD_BEEF, 32'd4);
    @(negedge clk);
    chk("sw_req", 32'(mem_req), 32'd1);
    chk("sw_we", 32'(mem_we), 32'd1);
    chk("sw_addr", mem_addr, 32'h204);
    chk("sw_data", mem_data_out, 32'hDEAD_BEEF);
    chk("sw_width", 32'(mem_acc_width), 32'd2);
    mem_ready = 1'b1;
    wait_out("sw");
    mem_ready = 1'b0;
    chk("sw_val", val_out, 32'd0);
    chk("sw_trap", 32'(trap), 32'd0);
    release_out("sw");

    // Misaligned word load traps without touching memory
    r0 = req_cycles;
    issue(7'b0000011, 3'b010, 7'd0, 32'h0, 32'h100, 32'd0, 32'd2);
    wait_out("lw_mis");
    chk("lw_mis_trap", 32'(trap), 32'd1);
    chk("lw_mis_noreq", 32'(req_cycles - r0), 32'd0);
    release_out("lw_mis");

    issue(7'b1100011, 3'b000, 7'd0, 32'h40, 32'd9, 32'd9, 32'h20);
    wait_out("beq");
    chk("beq_redirect", 32'(redirect), 32'd1);
    chk("beq_pc", pc_out, 32'h60);
    chk("beq_val", val_out, 32'd0);
    release_out("beq");

    issue(7'b1100011, 3'b001, 7'd0, 32'h40, 32'd9, 32'd9, 32'h20);
    wait_out("bne");
    chk("bne_redirect", 32'(redirect), 32'd0);
    chk("bne_trap", 32'(trap), 32'd0);
    release_out("bne");

    // JALR held in DONE by back-pressure
    issue(7'b1100111, 3'b000, 7'd0, 32'h200, 32'h35, 32'd0, 32'd0);
    wait_out("jalr");
    for (int i = 0; i < 5; i++) begin
      chk("jalr_val", val_out, 32'h204);
      chk("jalr_pc", pc_out, 32'h34);
      chk("jalr_in_ready", 32'(in_ready), 32'd0);
      chk("jalr_hold_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    release_out("jalr");

    issue(7'b1111111, 3'b000, 7'd0, 32'h0, 32'd0, 32'd0, 32'd0);
    wait_out("badop");
    chk("badop_trap", 32'(trap), 32'd1);
    release_out("badop");

    issue(7'b0110011, 3'b000, 7'b0000001, 32'h0, 32'd6, 32'd7, 32'd0);
    wait_out("mul");
`ifdef EXEC_UNIT_MUL_EN
    chk("mul_val", val_out, 32'd42);
    chk("mul_trap", 32'(trap), 32'd0);
`else
    chk("mul_trap", 32'(trap), 32'd1);
`endif
    release_out("mul");

    // Reset asserted mid-access
    mem_ready = 1'b0;
    issue(7'b0000011, 3'b010, 7'd0, 32'h0, 32'h100, 32'd0, 32'd0);
    @(negedge clk);
    chk("rstmem_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rstmem_drop", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmem_in_ready", 32'(in_ready), 32'd1);
    chk("rstmem_out_valid", 32'(out_valid), 32'd0);
    chk("rstmem_pc", pc_out, RPC);

    issue(7'b0010011, 3'b000, 7'd0, 32'h0, 32'd1, 32'd0, 32'd1);
    wait_out("post_rst");
    chk("post_rst_val", val_out, 32'd2);
    release_out("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Parametrised, handshaked successor to the single-cycle execute stage.
- Executes one RV32I-style instruction at a time, with valid/ready handshakes on the decode side and the writeback side.
- Performs byte/half/word loads and stores, with sign/zero extension and misalignment trapping, over a req/ready memory port.
- Resolves branches and jumps into a redirect. Sits between decode/regfile-read and writeback.

Parameters:
- XLEN, 32, datapath/address width (16 or 32); word accesses trap when XLEN=16.
- RESET_PC, 0, value of pc_out while idle or in reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  unit can accept an instruction
- op  in  7  opcode
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field
- pc_in  in  XLEN  instruction PC
- rs1  in  XLEN  source operand 1
- rs2  in  XLEN  source operand 2
- imm  in  XLEN  sign-extended immediate
- out_valid  out  1  result/redirect valid
- out_ready  in  1  writeback accepts result
- val_out  out  XLEN  result for rd
- pc_out  out  XLEN  redirect target
- redirect  out  1  taken branch/jump; qualified by out_valid
- trap  out  1  misaligned access or illegal opcode; qualified by out_valid
- mem_req  out  1  memory request
- mem_we  out  1  store
- mem_addr  out  XLEN  byte address
- mem_data_out  out  XLEN  store data (rs2)
- mem_acc_width  out  2  00 byte, 01 half, 10 word
- mem_data_in  in  XLEN  load data, right-aligned
- mem_ready  in  1  access complete this cycle

Behaviour:
- Reset: all outputs 0 except in_ready=1 and pc_out=RESET_PC. FSM goes to IDLE. Reset asserted mid-access drops mem_req at once and abandons the access.
- FSM states: IDLE, EXEC, MEM, DONE.
- IDLE: in_ready=1. When in_valid=1, latch op, funct3, funct7, pc_in, rs1, rs2, imm, then go to EXEC.
- EXEC (1 cycle):
  - ALU/LUI/AUIPC/JAL/JALR/BRANCH: compute the result into output registers, go to DONE. Latency is accept edge + 2 edges, i.e. out_valid is high in the second cycle after the accept cycle.
  - LOAD/STORE: compute addr = rs1+imm (XLEN-bit wrap). Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or word access with XLEN=16 → trap=1, no mem_req, go to DONE. Otherwise go to MEM.
  - Unknown op: trap=1, go to DONE.
- MEM:
  - mem_req=1, with mem_addr, mem_we, mem_data_out and mem_acc_width held stable until mem_ready=1.
  - On the mem_ready cycle, capture the load result, deassert mem_req next cycle, go to DONE.
  - mem_ready=1 on the first MEM cycle is legal: single-cycle access.
  - No timeout.
- Load extension: funct3 000 LB and 001 LH sign-extend; 100 LBU and 101 LHU zero-extend; 010 LW takes the value as-is. Stores write val_out=0.
- DONE: out_valid=1 and all outputs held until out_ready=1. Return to IDLE on the cycle after the handshake. in_ready=0 in EXEC, MEM and DONE, so exactly one instruction is in flight.
- Arithmetic:
  - ADD/SUB: SUB when funct7[5]=1 and op is register-register only.
  - SRA: selected by funct7[5] for both forms.
  - Shift amount: rs2/imm[$clog2(XLEN)-1:0].
  - SLT signed, SLTU unsigned.
- Branch: compare EQ/NE/LT/GE/LTU/GEU on rs1, rs2. Taken → redirect=1, pc_out=pc_in+imm. Not taken → redirect=0. Branches write val_out=0.
- JAL: val_out=pc_in+4, pc_out=pc_in+imm, redirect=1.
- JALR: val_out=pc_in+4, pc_out=(rs1+imm) with bit0 cleared, redirect=1.
- LUI: val_out=imm. AUIPC: val_out=pc_in+imm.
- in_valid while busy is ignored; the producer holds it.

Optional Feature:
- Macro: EXEC_UNIT_MUL_EN.
- Defined: op=0110011 with funct7=0000001 and funct3=000 (MUL) enters an extra MUL state. An iterative shift-add multiplier runs for XLEN cycles and returns the low XLEN bits of the product, then goes to DONE.
- Undefined: that encoding raises trap=1.

Decomposition:
- Package exec_pkg holds:
  - opcode constants (OP_LUI … OP_INTEGER);
  - funct3 ALU/branch/load constants;
  - MEM_ACC_8/16/32;
  - FSM state enum.
- One sub-module, exec_alu: combinational XLEN-wide ALU plus branch comparator.
- The FSM, address adder, load extension and multiplier stay in exec_unit.

Test Plan:
- ADDI with rs1=5, imm=-7 → out_valid two cycles after accept, val_out=0xFFFFFFFE, redirect=0, trap=0.
- LB at rs1=0x100, imm=3, mem_data_in=0x80, mem_ready delayed 3 cycles → mem_req held 4 cycles at addr 0x103, width 00; val_out=0xFFFFFF80. LBU with the same data → 0x00000080.
- LW at addr 0x102 → trap=1, mem_req never asserted, out_valid=1.
- BEQ with rs1=rs2=9, pc_in=0x40, imm=0x20 → redirect=1, pc_out=0x60. BNE with the same operands → redirect=0.
- out_ready held low 5 cycles after a JALR with rs1=0x35, imm=0 → val_out=pc_in+4 and pc_out=0x34 stable throughout, in_ready=0.
- Reset pulsed while in MEM → mem_req=0 immediately; in_ready=1 and out_valid=0 after release.
